// File: rtl/key_pulse_array_if.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse_array_if
// Purpose  : Key inputs and per-channel pulse outputs of key_pulse_array.
// Revision : 1.0
// ============================================================================
interface key_pulse_array_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_i;
  logic [N_KEYS-1:0] repeat_en_i;
  logic [N_KEYS-1:0] held_o;
  logic [N_KEYS-1:0] press_o;
  logic [N_KEYS-1:0] release_o;
  logic [N_KEYS-1:0] rpt_o;

  modport slave (
    input  key_i, repeat_en_i,
    output held_o, press_o, release_o, rpt_o
  );

  modport master (
    output key_i, repeat_en_i,
    input  held_o, press_o, release_o, rpt_o
  );
endinterface
`default_nettype wire

// File: rtl/key_pulse_array.sv
`default_nettype none
// ============================================================================
// Module   : key_pulse_array
// Purpose  : Per-key synchroniser, debouncer, press/release pulses, auto-repeat.
// Revision : 1.0
// ============================================================================
module key_pulse_array #(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  key_pulse_array_if.slave  bus
);

  localparam int c_DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_RW   = $clog2(c_RMAX + 1);

  localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RW-1:0] c_DLY_LAST  = c_RW'(REPEAT_DELAY - 1);
  localparam logic [c_RW-1:0] c_RATE_LAST = c_RW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RATE  = 2'd2;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [c_DW-1:0]        dcnt_q, dcnt_d;
    logic                   held_q, held_d;
    logic                   press_q, release_q;
    logic                   rpt_q, rpt_d;
    logic [1:0]             state_q, state_d;
    logic [c_RW-1:0]        rcnt_q, rcnt_d;
    logic                   w_ks;
    logic                   w_en;

    assign w_ks = sync_q[SYNC_STAGES-1];
    assign w_en = bus.repeat_en_i[g];

    // Any return of the synchronised level to held restarts the count.
    always_comb begin
      held_d = held_q;
      dcnt_d = dcnt_q;
      if (w_ks == held_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == c_DB_LAST) begin
        held_d = w_ks;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + c_DW'(1);
      end
    end

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
        S_IDLE: begin
          if (held_d && w_en) begin
            state_d = S_DELAY;
            rcnt_d  = '0;
          end
        end
        S_DELAY: begin
          if (!held_d || !w_en) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == c_DLY_LAST) begin
            state_d = S_RATE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + c_RW'(1);
          end
        end
        S_RATE: begin
          if (!held_d || !w_en) begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == c_RATE_LAST) begin
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + c_RW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    // A release landing on a terminal count suppresses that repeat pulse.
    always_comb begin
      rpt_d = 1'b0;
      if (held_d && w_en) begin
        rpt_d = ((state_q == S_DELAY) && (rcnt_q == c_DLY_LAST)) ||
                ((state_q == S_RATE)  && (rcnt_q == c_RATE_LAST));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q    <= '0;
        dcnt_q    <= '0;
        held_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rpt_q     <= 1'b0;
        state_q   <= S_IDLE;
        rcnt_q    <= '0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.key_i[g]};
        dcnt_q    <= dcnt_d;
        held_q    <= held_d;
        press_q   <= held_d & ~held_q;
        release_q <= ~held_d & held_q;
        rpt_q     <= rpt_d;
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
      end
    end

    assign bus.held_o[g]    = held_q;
    assign bus.press_o[g]   = press_q;
    assign bus.release_o[g] = release_q;
    assign bus.rpt_o[g]     = rpt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_pulse_array
// Purpose  : Scoreboard bench for key_pulse_array pulse timing.
// Revision : 1.0
// ============================================================================
module tb_key_pulse_array;

  localparam int c_SYNC = 2;
  localparam int c_DEB  = 4;
  localparam int c_DLY  = 8;
  localparam int c_RATE = 3;
  localparam int c_LAT  = c_SYNC + c_DEB;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_RPT     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_pulse_array_if #(.N_KEYS(4)) bus ();

  key_pulse_array #(
    .N_KEYS          (4),
    .SYNC_STAGES     (c_SYNC),
    .DEBOUNCE_CYCLES (c_DEB),
    .REPEAT_DELAY    (c_DLY),
    .REPEAT_RATE     (c_RATE)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int ch;
    int kind;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad   = 0;

  function automatic void push_ev(int c, int ch, int kind);
    ev_t e;
    e.c    = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endfunction

  // Expected {rpt, release, press} for cycle c; matching entries leave the queue.
  function automatic logic [11:0] pop_exp(int c);
    logic [11:0] v;
    v = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c == c) begin
        v[sb[i].kind*4 + sb[i].ch] = 1'b1;
        sb.delete(i);
      end
    end
    return v;
  endfunction

  task automatic test_reset();
    logic [11:0] e;
    bus.key_i       = 4'hF;
    bus.repeat_en_i = 4'h0;
    rst             = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      total++;
      if ({bus.held_o, bus.rpt_o, bus.release_o, bus.press_o} !== 16'h0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=0", cyc,
                 {bus.held_o, bus.rpt_o, bus.release_o, bus.press_o});
      end
    end
    rst = 1'b0;
    for (int ch = 0; ch < 4; ch++) push_ev(cyc + c_LAT, ch, K_PRESS);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      e = pop_exp(cyc);
      total++;
      if ({bus.rpt_o, bus.release_o, bus.press_o} !== e) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc,
                 {bus.rpt_o, bus.release_o, bus.press_o}, e);
      end
      if (t == 8) begin
        bus.key_i = 4'h0;
        for (int ch = 0; ch < 4; ch++) push_ev(cyc + c_LAT, ch, K_RELEASE);
      end
    end
  endtask

  task automatic test_clean();
    logic [11:0] e;
    int          c0;
    int          hcnt;
    logic [3:0]  eh;
    c0   = 0;
    hcnt = 0;
    bus.repeat_en_i = 4'h0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      e = pop_exp(cyc);
      total++;
      if ({bus.rpt_o, bus.release_o, bus.press_o} !== e) begin
        bad++;
        $display("FAIL clean_pulses cyc=%0d got=%h want=%h", cyc,
                 {bus.rpt_o, bus.release_o, bus.press_o}, e);
      end
      if (t > 0) begin
        eh = {3'b000, (cyc >= c0 + c_LAT) && (cyc < c0 + c_LAT + 20)};
        total++;
        if (bus.held_o !== eh) begin
          bad++;
          $display("FAIL clean_held cyc=%0d got=%h want=%h", cyc, bus.held_o, eh);
        end
        if (bus.held_o[0] === 1'b1) hcnt++;
      end
      if (t == 0) begin
        c0 = cyc;
        bus.key_i[0] = 1'b1;
        push_ev(cyc + c_LAT, 0, K_PRESS);
      end else if (t == 20) begin
        bus.key_i[0] = 1'b0;
        push_ev(cyc + c_LAT, 0, K_RELEASE);
      end
    end
    total++;
    if (hcnt != 20) begin
      bad++;
      $display("FAIL clean_held_len got=%0d want=20", hcnt);
    end
  endtask

  task automatic test_bounce();
    logic [11:0] e;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      e = pop_exp(cyc);
      total++;
      if ({bus.rpt_o, bus.release_o, bus.press_o} !== e) begin
        bad++;
        $display("FAIL bounce cyc=%0d got=%h want=%h", cyc,
                 {bus.rpt_o, bus.release_o, bus.press_o}, e);
      end
      if (t < 20) bus.key_i[1] = ((t % 4) != 3);
      else        bus.key_i[1] = (t < 30);
      if (t == 20) push_ev(cyc + c_LAT, 1, K_PRESS);
      if (t == 30) push_ev(cyc + c_LAT, 1, K_RELEASE);
    end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      e = pop_exp(cyc);
      total++;
      if ({bus.held_o, bus.rpt_o, bus.release_o, bus.press_o} !== {4'h0, e}) begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%h want=%h", cyc,
                 {bus.held_o, bus.rpt_o, bus.release_o, bus.press_o}, {4'h0, e});
      end
      bus.key_i[1] = (t < 3);
    end
  endtask

  // toggle=1 drops repeat_en for two cycles starting at P+12.
  task automatic test_repeat(input bit toggle);
    logic [11:0] e;
    int          p;
    p = 0;
    bus.repeat_en_i[2] = 1'b1;
    for (int t = 0; t < 45; t++) begin
      @(negedge clk);
      e = pop_exp(cyc);
      total++;
      if ({bus.rpt_o, bus.release_o, bus.press_o} !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", toggle ? "toggle" : "repeat", cyc,
                 {bus.rpt_o, bus.release_o, bus.press_o}, e);
      end
      if (t == 0) begin
        bus.key_i[2] = 1'b1;
        p = cyc + c_LAT;
        push_ev(p, 2, K_PRESS);
        if (!toggle) begin
          for (int k = 0; p + c_DLY + k*c_RATE < p + 30; k++)
            push_ev(p + c_DLY + k*c_RATE, 2, K_RPT);
        end else begin
          push_ev(p + 8, 2, K_RPT);
          push_ev(p + 11, 2, K_RPT);
          push_ev(p + 23, 2, K_RPT);
          push_ev(p + 26, 2, K_RPT);
          push_ev(p + 29, 2, K_RPT);
        end
      end
      if (toggle && t == 18) bus.repeat_en_i[2] = 1'b0;
      if (toggle && t == 20) bus.repeat_en_i[2] = 1'b1;
      if (t == 30) begin
        bus.key_i[2] = 1'b0;
        push_ev(cyc + c_LAT, 2, K_RELEASE);
      end
    end
    bus.repeat_en_i[2] = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [11:0] e;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      e = pop_exp(cyc);
      total++;
      if ({bus.rpt_o, bus.release_o, bus.press_o} !== e) begin
        bad++;
        $display("FAIL simultaneous cyc=%0d got=%h want=%h", cyc,
                 {bus.rpt_o, bus.release_o, bus.press_o}, e);
      end
      if (t == 0) begin
        bus.key_i[0] = 1'b1;
        bus.key_i[3] = 1'b1;
        push_ev(cyc + c_LAT, 0, K_PRESS);
        push_ev(cyc + c_LAT, 3, K_PRESS);
      end
      if (t == 10) begin
        bus.key_i[0] = 1'b0;
        bus.key_i[3] = 1'b0;
        push_ev(cyc + c_LAT, 0, K_RELEASE);
        push_ev(cyc + c_LAT, 3, K_RELEASE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_repeat(1'b0);
    test_repeat(1'b1);
    test_simultaneous();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
